microwave_time_setter: RTL and testbench
========================================

Name: microwave_time_setter

Overview:
Front-end controller for the microwave timer. It owns time entry from the user buttons and holds the preset minutes/seconds. It drives the countdown block's preset and run-enable, and consumes the countdown's end-of-time flag. It also sequences idle, run, pause and done, including a fixed-length done beep.

Parameters:
MAX_MIN, 59, upper saturation value for minutes.
BEEP_CYCLES, 3, number of clk_1Hz cycles the beep output is held in DONE.

Ports:
clk_1Hz  input  1  system tick clock.
rst  input  1  synchronous, active-high reset.
inc  input  1  increment button, level; acted on at its rising edge.
dec  input  1  decrement button, level; acted on at its rising edge.
unit_sel  input  1  selects the field edited by inc/dec: 0 = seconds, 1 = minutes.
start_btn  input  1  start/resume button; acted on at its rising edge.
stop_btn  input  1  pause/cancel button; acted on at its rising edge.
door_open  input  1  door switch, level, 1 = open.
timer_end  input  1  end-of-time flag from the countdown block.
minutes_set  output  6  preset minutes to the countdown block, range 0..MAX_MIN.
seconds_set  output  6  preset seconds to the countdown block, range 0..59.
start  output  1  run-enable to the countdown block.
beep  output  1  done indicator.
state_o  output  2  current state, for display/debug.

Behaviour:
- All registers update on the posedge of clk_1Hz only.
- Reset has priority over every other input: state = IDLE, minutes_set = 0, seconds_set = 0, start = 0, beep = 0, beep counter = 0, edge-detector history = 0.
- Edge detection:
  - Each button (inc, dec, start_btn, stop_btn) has a 1-cycle history register.
  - An event fires when the button is 1 now and was 0 in the previous cycle.
  - Holding a button produces exactly one event.
  - Events act in the same cycle they are detected; registered outputs change at that clock edge.
- States:
  - IDLE = 0: editable.
  - RUN = 1: start = 1.
  - PAUSE = 2: start = 0; preset is held.
  - DONE = 3: beep = 1.
- start = (state == RUN), registered. beep = (state == DONE), registered.
- IDLE editing, seconds field (unit_sel = 0):
  - inc: seconds + 1. At 59, seconds wrap to 0 and minutes + 1. If minutes == MAX_MIN and seconds == 59, nothing changes.
  - dec: seconds - 1. At 0 with minutes > 0, seconds go to 59 and minutes - 1. At 0:00, nothing changes.
- IDLE editing, minutes field (unit_sel = 1):
  - inc saturates at MAX_MIN.
  - dec saturates at 0.
  - Seconds are unchanged.
- inc and dec events in the same cycle: no change.
- IDLE transitions:
  - start event with door_open = 0 and time != 0:00 goes to RUN.
  - start event with time == 0:00 or door open is ignored.
  - stop event clears the time to 0:00.
- inc/dec events outside IDLE are ignored; the preset is frozen.
- RUN transitions, in priority order:
  1. timer_end = 1 goes to DONE and loads the beep counter with BEEP_CYCLES-1.
  2. door_open = 1 goes to PAUSE.
  3. A stop event goes to PAUSE.
  4. A start event in RUN has no effect.
- PAUSE transitions:
  - A start event with the door closed goes to RUN (resume; the countdown keeps its remaining value).
  - A stop event goes to IDLE with the time cleared to 0:00.
  - A start event with the door open is ignored.
- DONE transitions:
  - The beep counter decrements each cycle.
  - When it reaches 0, go to IDLE with the time cleared to 0:00.
  - A stop event goes to IDLE immediately, time cleared.
  - Other buttons are ignored.
- timer_end outside RUN is ignored.
- Reset mid-RUN or mid-DONE: next state IDLE, start = 0 at that edge, preset cleared.
- Arithmetic:
  - 6-bit unsigned.
  - No output ever exceeds 59 seconds or MAX_MIN minutes.
  - Compare before adding; no reliance on overflow.

Decomposition:
- Shared package microwave_pkg holds:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2-bit).
  - SEC_MAX = 59.
  - Default MAX_MIN and BEEP_CYCLES constants, also reused by the countdown and display blocks.
- One sub-module, edge_pulse: 1-bit rising-edge detector with synchronous reset, instantiated once per button.

Test Plan:
- Reset, then one inc with unit_sel = 0 repeated 61 times -> preset 1:01. Reset mid-sequence -> 0:00 and state_o = 0.
- Preset 0:00, one dec -> stays 0:00. Preset 1:00, one dec -> 0:59. unit_sel = 1 inc 65 times -> minutes = 59. inc and dec together -> unchanged.
- Preset 0:05, start event -> start = 1 and state_o = 1 at the next edge. Hold start_btn 4 cycles -> only one event. Preset 0:00, start -> stays IDLE.
- In RUN: door_open = 1 -> PAUSE, start = 0. Start with the door open -> ignored. Door closed, then start -> RUN. Stop -> PAUSE. Second stop -> IDLE with preset 0:00.
- In RUN, pulse timer_end -> DONE with beep = 1 for exactly 3 cycles, then IDLE with preset 0:00. A stop event during DONE -> IDLE on the next edge.
- inc event while in RUN or PAUSE -> preset unchanged. timer_end while IDLE -> no state change.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer blocks: state encodings, limits and mm:ss step helpers.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [5:0] SEC_MAX         = 6'd59;
    localparam int         MAX_MIN_DEF     = 59;
    localparam int         BEEP_CYCLES_DEF = 3;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
    } mmss_t;

    // Limits are compared before stepping so nothing relies on 6-bit wraparound.
    function automatic mmss_t time_inc(input mmss_t t, input logic unit_min, input logic [5:0] max_min);
        mmss_t r;
        r = t;
        if (unit_min) begin
            if (t.min < max_min) r.min = t.min + 6'd1;
        end else if (t.sec < SEC_MAX) begin
            r.sec = t.sec + 6'd1;
        end else if (t.min < max_min) begin
            r.sec = 6'd0;
            r.min = t.min + 6'd1;
        end
        return r;
    endfunction

    function automatic mmss_t time_dec(input mmss_t t, input logic unit_min);
        mmss_t r;
        r = t;
        if (unit_min) begin
            if (t.min != 6'd0) r.min = t.min - 6'd1;
        end else if (t.sec != 6'd0) begin
            r.sec = t.sec - 6'd1;
        end else if (t.min != 6'd0) begin
            r.sec = SEC_MAX;
            r.min = t.min - 6'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/microwave_time_setter_edge_pulse.sv
// Rising-edge detector: one-cycle pulse the cycle a level input goes 0->1.
// Pulse is combinational from the input and a registered history bit.
module edge_pulse (
    input  logic clk_1Hz,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk_1Hz) begin
        if (rst) hist_q <= 1'b0;
        else     hist_q <= btn_i;
    end

    assign pulse_o = btn_i & ~hist_q;

endmodule

// File: rtl/microwave_time_setter.sv
// Microwave front end: button time entry in IDLE and IDLE/RUN/PAUSE/DONE sequencing with a fixed beep.
// All outputs registered; button events take effect at the edge on which they are detected.
module microwave_time_setter
    import microwave_pkg::*;
#(
    parameter int MAX_MIN     = MAX_MIN_DEF,
    parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
) (
    input  logic       clk_1Hz,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       unit_sel,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_open,
    input  logic       timer_end,
    output logic [5:0] minutes_set,
    output logic [5:0] seconds_set,
    output logic       start,
    output logic       beep,
    output logic [1:0] state_o
);

    localparam logic [5:0] MAX_MIN_L = 6'(MAX_MIN);
    localparam logic [7:0] BEEP_LOAD = 8'(BEEP_CYCLES - 1);

    logic   inc_ev, dec_ev, start_ev, stop_ev;
    state_e state_q;
    mmss_t  time_q, time_d;
    logic   start_q, beep_q;
    logic [7:0] beep_cnt_q;
    logic   time_nz;

    edge_pulse u_inc   (.clk_1Hz(clk_1Hz), .rst(rst), .btn_i(inc),       .pulse_o(inc_ev));
    edge_pulse u_dec   (.clk_1Hz(clk_1Hz), .rst(rst), .btn_i(dec),       .pulse_o(dec_ev));
    edge_pulse u_start (.clk_1Hz(clk_1Hz), .rst(rst), .btn_i(start_btn), .pulse_o(start_ev));
    edge_pulse u_stop  (.clk_1Hz(clk_1Hz), .rst(rst), .btn_i(stop_btn),  .pulse_o(stop_ev));

    // Simultaneous inc and dec cancel out.
    always_comb begin
        time_d = time_q;
        if (inc_ev && !dec_ev)      time_d = time_inc(time_q, unit_sel, MAX_MIN_L);
        else if (dec_ev && !inc_ev) time_d = time_dec(time_q, unit_sel);
    end

    assign time_nz = |time_q;

    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            start_q    <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stop_ev) begin
                        time_q <= '0;
                    end else if (start_ev && !door_open && time_nz) begin
                        state_q <= ST_RUN;
                        start_q <= 1'b1;
                    end else begin
                        time_q <= time_d;
                    end
                end
                ST_RUN: begin
                    if (timer_end) begin
                        state_q    <= ST_DONE;
                        start_q    <= 1'b0;
                        beep_q     <= 1'b1;
                        beep_cnt_q <= BEEP_LOAD;
                    end else if (door_open || stop_ev) begin
                        state_q <= ST_PAUSE;
                        start_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (stop_ev) begin
                        state_q <= ST_IDLE;
                        time_q  <= '0;
                    end else if (start_ev && !door_open) begin
                        state_q <= ST_RUN;
                        start_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (stop_ev || beep_cnt_q == 8'd0) begin
                        state_q    <= ST_IDLE;
                        beep_q     <= 1'b0;
                        beep_cnt_q <= '0;
                        time_q     <= '0;
                    end else begin
                        beep_cnt_q <= beep_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    start_q <= 1'b0;
                    beep_q  <= 1'b0;
                end
            endcase
        end
    end

    assign minutes_set = time_q.min;
    assign seconds_set = time_q.sec;
    assign start       = start_q;
    assign beep        = beep_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_microwave_time_setter.sv
// Bench for microwave_time_setter: directed plan with literal checks plus randomized run against a total-seconds model.
module tb_microwave_time_setter;

    localparam int MAXM  = 59;
    localparam int BEEPN = 3;
    localparam int TMAX  = MAXM * 60 + 59;

    logic       clk_1Hz = 1'b0;
    logic       rst = 1'b1, inc = 1'b0, dec = 1'b0, unit_sel = 1'b0;
    logic       start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0, timer_end = 1'b0;
    logic [5:0] minutes_set, seconds_set;
    logic       start, beep;
    logic [1:0] state_o;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    // Model: preset held as total seconds; state as 0..3; beep_left counts remaining DONE cycles.
    int   m_t = 0, m_state = 0, beep_left = 0;
    logic h_inc = 1'b0, h_dec = 1'b0, h_start = 1'b0, h_stop = 1'b0;

    microwave_time_setter #(.MAX_MIN(MAXM), .BEEP_CYCLES(BEEPN)) dut (
        .clk_1Hz(clk_1Hz), .rst(rst), .inc(inc), .dec(dec), .unit_sel(unit_sel),
        .start_btn(start_btn), .stop_btn(stop_btn), .door_open(door_open), .timer_end(timer_end),
        .minutes_set(minutes_set), .seconds_set(seconds_set), .start(start), .beep(beep), .state_o(state_o)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    always @(posedge clk_1Hz) begin
        bit e_inc, e_dec, e_start, e_stop;
        e_inc = inc && !h_inc;  e_dec = dec && !h_dec;
        e_start = start_btn && !h_start;  e_stop = stop_btn && !h_stop;
        if (rst) begin
            m_t = 0; m_state = 0; beep_left = 0;
            h_inc = 0; h_dec = 0; h_start = 0; h_stop = 0;
        end else begin
            h_inc = inc; h_dec = dec; h_start = start_btn; h_stop = stop_btn;
            case (m_state)
                0: if (e_stop) m_t = 0;
                   else if (e_start && !door_open && m_t != 0) m_state = 1;
                   else if (e_inc != e_dec) begin
                       if (unit_sel) begin
                           if (e_inc && m_t / 60 < MAXM) m_t += 60;
                           if (e_dec && m_t / 60 > 0)    m_t -= 60;
                       end else begin
                           if (e_inc && m_t < TMAX) m_t += 1;
                           if (e_dec && m_t > 0)    m_t -= 1;
                       end
                   end
                1: if (timer_end) begin m_state = 3; beep_left = BEEPN; end
                   else if (door_open || e_stop) m_state = 2;
                2: if (e_stop) begin m_state = 0; m_t = 0; end
                   else if (e_start && !door_open) m_state = 1;
                default: begin
                    beep_left -= 1;
                    if (e_stop || beep_left == 0) begin m_state = 0; m_t = 0; beep_left = 0; end
                end
            endcase
        end
    end

    task automatic cmp(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk_1Hz) begin
        if (chk_en) begin
            cmp("state_o", int'(state_o), m_state);
            cmp("minutes_set", int'(minutes_set), m_t / 60);
            cmp("seconds_set", int'(seconds_set), m_t % 60);
            cmp("start", int'(start), int'(m_state == 1));
            cmp("beep", int'(beep), int'(m_state == 3));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk_1Hz); #1; end
    endtask

    task automatic press(input int which);
        case (which)
            0: inc = 1'b1;
            1: dec = 1'b1;
            2: start_btn = 1'b1;
            default: stop_btn = 1'b1;
        endcase
        cyc(1);
        inc = 1'b0; dec = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(1); rst = 1'b0;
    endtask

    // Literal check of both the DUT and the model against a hand-computed mm:ss/state.
    task automatic lit(input string name, input int mm, input int ss, input int st);
        cmp({name, " dut min"}, int'(minutes_set), mm);
        cmp({name, " dut sec"}, int'(seconds_set), ss);
        cmp({name, " dut state"}, int'(state_o), st);
        cmp({name, " model time"}, m_t, mm * 60 + ss);
        cmp({name, " model state"}, m_state, st);
    endtask

    task automatic set_secs(input int n);
        unit_sel = 1'b0;
        repeat (n) press(0);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        lit("reset", 0, 0, 0);
        cmp("reset start", int'(start), 0);
        cmp("reset beep", int'(beep), 0);

        set_secs(61);
        lit("61 inc", 1, 1, 0);
        set_secs(3);
        do_reset();
        lit("mid reset", 0, 0, 0);

        unit_sel = 1'b0; press(1);
        lit("dec at 0:00", 0, 0, 0);
        unit_sel = 1'b1; press(0);
        unit_sel = 1'b0; press(1);
        lit("dec 1:00", 0, 59, 0);
        unit_sel = 1'b1;
        repeat (65) press(0);
        lit("min sat", 59, 59, 0);
        set_secs(1);
        lit("max sat", 59, 59, 0);
        inc = 1'b1; dec = 1'b1; cyc(1); inc = 1'b0; dec = 1'b0; cyc(1);
        lit("inc+dec", 59, 59, 0);

        do_reset();
        press(2);
        lit("start at 0:00", 0, 0, 0);
        set_secs(5);
        start_btn = 1'b1; cyc(1);
        lit("start", 0, 5, 1);
        cmp("start out", int'(start), 1);
        door_open = 1'b1; cyc(1); door_open = 1'b0; cyc(2);
        lit("held start", 0, 5, 2);
        start_btn = 1'b0; cyc(1);
        press(3);
        lit("stop pause", 0, 0, 0);

        set_secs(5);
        press(2);
        door_open = 1'b1; cyc(1);
        lit("door pause", 0, 5, 2);
        press(2);
        lit("start door open", 0, 5, 2);
        door_open = 1'b0; cyc(1);
        press(0);
        lit("inc in pause", 0, 5, 2);
        press(2);
        lit("resume", 0, 5, 1);
        press(0);
        lit("inc in run", 0, 5, 1);
        press(3);
        lit("stop run", 0, 5, 2);
        press(3);
        lit("stop pause", 0, 0, 0);

        set_secs(5);
        press(2);
        timer_end = 1'b1; cyc(1); timer_end = 1'b0;
        lit("done 1", 0, 5, 3);
        cmp("beep 1", int'(beep), 1);
        cyc(1); cmp("beep 2", int'(beep), 1);
        cyc(1); cmp("beep 3", int'(beep), 1);
        cyc(1);
        lit("done end", 0, 0, 0);
        cmp("beep off", int'(beep), 0);

        set_secs(2);
        press(2);
        timer_end = 1'b1; cyc(1); timer_end = 1'b0;
        stop_btn = 1'b1; cyc(1); stop_btn = 1'b0;
        lit("stop in done", 0, 0, 0);
        timer_end = 1'b1; cyc(1); timer_end = 1'b0;
        lit("tend idle", 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            inc       = ($urandom_range(0, 2) == 0);
            dec       = ($urandom_range(0, 4) == 0);
            unit_sel  = ($urandom_range(0, 3) == 0);
            start_btn = ($urandom_range(0, 5) == 0);
            stop_btn  = ($urandom_range(0, 11) == 0);
            door_open = ($urandom_range(0, 9) == 0);
            timer_end = ($urandom_range(0, 14) == 0);
            cyc(1);
        end
        rst = 1'b0; inc = 1'b0; dec = 1'b0; start_btn = 1'b0; stop_btn = 1'b0;
        door_open = 1'b0; timer_end = 1'b0;
        cyc(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
